// File: rtl/zynq_axil_shell_pkg.sv
// Shared definitions for the AXI4-Lite FIFO shell: address regions,
// response codes and the decoded-address record.
package zynq_axil_shell_pkg;

  // Region selector lives in addr[9:8]
  localparam logic [1:0] region_csr_c       = 2'b00;
  localparam logic [1:0] region_ps2pl_c     = 2'b01;
  localparam logic [1:0] region_pl2ps_c     = 2'b10;
  localparam logic [1:0] region_pl2ps_cnt_c = 2'b11;

  localparam logic [1:0] resp_okay_c   = 2'b00;
  localparam logic [1:0] resp_slverr_c = 2'b10;

  typedef struct packed {
    logic [1:0] region;
    logic [5:0] idx;
  } axil_dec_s;

  // Takes the word address (addr[9:2]); byte-lane bits never reach here.
  function automatic axil_dec_s decode_addr(input logic [7:0] word_addr);
    axil_dec_s d;
    d.region = word_addr[7:6];
    d.idx    = word_addr[5:0];
    return d;
  endfunction

endpackage

// File: rtl/zynq_axil_shell_fifo.sv
// 1r1w circular-buffer FIFO with occupancy count. Full/empty are derived
// from the registered count, so a same-cycle pop never frees a slot for a
// same-cycle push.
module zynq_axil_shell_fifo #(
  parameter int els_p = 16
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic [31:0]              data_i,
  input  logic                     v_i,
  output logic                     ready_o,
  output logic [31:0]              data_o,
  output logic                     v_o,
  input  logic                     yumi_i,
  output logic [$clog2(els_p):0]   count_o
);

  localparam int ptr_w_lp = $clog2(els_p);
  localparam int cnt_w_lp = ptr_w_lp + 1;

  logic [31:0]         mem_q [els_p];
  logic [ptr_w_lp-1:0] wr_ptr_q, rd_ptr_q;
  logic [cnt_w_lp-1:0] count_q;
  logic                push, pop;

  assign v_o     = (count_q != '0);
  assign ready_o = (count_q != cnt_w_lp'(els_p));
  assign push    = v_i & ready_o;
  assign pop     = yumi_i & v_o;
  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Storage array; contents are don't-care while empty, so no reset
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= data_i;
  end

  // Pointers wrap naturally at the power-of-two depth
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop)      count_q <= count_q + 1'b1;
      else if (pop && !push) count_q <= count_q - 1'b1;
    end
  end

endmodule

// File: rtl/zynq_axil_fifo_shell.sv
// AXI4-Lite slave shell: CSR bank plus PS->PL and PL->PS FIFOs with
// occupancy/credit visibility, sitting behind a PS GP port.
module zynq_axil_fifo_shell
  import zynq_axil_shell_pkg::*;
#(
  parameter int num_regs_p        = 4,
  parameter int num_fifo_ps2pl_p  = 2,
  parameter int num_fifo_pl2ps_p  = 2,
  parameter int fifo_els_p        = 16,
  parameter int axil_data_width_p = 32,
  parameter int axil_addr_width_p = 10
) (
  input  logic                             clk_i,
  input  logic                             reset_i,
  input  logic [axil_addr_width_p-1:0]     s_axil_awaddr_i,
  input  logic                             s_axil_awvalid_i,
  output logic                             s_axil_awready_o,
  input  logic [axil_data_width_p-1:0]     s_axil_wdata_i,
  input  logic [axil_data_width_p/8-1:0]   s_axil_wstrb_i,
  input  logic                             s_axil_wvalid_i,
  output logic                             s_axil_wready_o,
  output logic [1:0]                       s_axil_bresp_o,
  output logic                             s_axil_bvalid_o,
  input  logic                             s_axil_bready_i,
  input  logic [axil_addr_width_p-1:0]     s_axil_araddr_i,
  input  logic                             s_axil_arvalid_i,
  output logic                             s_axil_arready_o,
  output logic [axil_data_width_p-1:0]     s_axil_rdata_o,
  output logic [1:0]                       s_axil_rresp_o,
  output logic                             s_axil_rvalid_o,
  input  logic                             s_axil_rready_i,
  output logic [num_regs_p*32-1:0]         csr_data_o,
  output logic [num_regs_p-1:0]            csr_w_v_o,
  output logic [num_fifo_ps2pl_p*32-1:0]   ps2pl_data_o,
  output logic [num_fifo_ps2pl_p-1:0]      ps2pl_v_o,
  input  logic [num_fifo_ps2pl_p-1:0]      ps2pl_yumi_i,
  input  logic [num_fifo_pl2ps_p*32-1:0]   pl2ps_data_i,
  input  logic [num_fifo_pl2ps_p-1:0]      pl2ps_v_i,
  output logic [num_fifo_pl2ps_p-1:0]      pl2ps_ready_o
);

  localparam int cnt_w_lp = $clog2(fifo_els_p) + 1;

  logic       aw_held_q, w_held_q;
  logic [7:0] aw_addr_q;
  logic [31:0] w_data_q;
  logic [3:0] w_strb_q;
  logic       aw_fire, w_fire, wr_exec;
  logic [7:0] wr_addr;
  logic [31:0] wr_data;
  logic [3:0] wr_strb;
  logic [1:0] wr_resp;
  axil_dec_s  wr_dec, rd_dec;
  logic       bvalid_q, rvalid_q, ar_fire;
  logic [31:0] rd_data;
  logic [1:0] rd_resp;

  logic [31:0]           csr_q [num_regs_p];
  logic [num_regs_p-1:0] csr_wr_mask;

  logic [num_fifo_ps2pl_p-1:0] ps2pl_push, ps2pl_ready;
  logic [cnt_w_lp-1:0]         ps2pl_count [num_fifo_ps2pl_p];
  logic [num_fifo_pl2ps_p-1:0] pl2ps_pop, pl2ps_v;
  logic [31:0]                 pl2ps_head  [num_fifo_pl2ps_p];
  logic [cnt_w_lp-1:0]         pl2ps_count [num_fifo_pl2ps_p];

  // Byte-lane bits and any address bits above the 1 KiB window are ignored
  logic unused_addr_bits;
  assign unused_addr_bits = ^{s_axil_awaddr_i, s_axil_araddr_i};

  assign s_axil_awready_o = ~aw_held_q & ~reset_i;
  assign s_axil_wready_o  = ~w_held_q & ~reset_i;
  assign s_axil_arready_o = ~rvalid_q & ~reset_i;
  assign s_axil_bvalid_o  = bvalid_q;
  assign s_axil_rvalid_o  = rvalid_q;

  assign aw_fire = s_axil_awvalid_i & s_axil_awready_o;
  assign w_fire  = s_axil_wvalid_i & s_axil_wready_o;
  assign ar_fire = s_axil_arvalid_i & s_axil_arready_o;

  // A beat arriving this cycle counts as held, giving single-cycle write latency
  assign wr_exec = (aw_held_q | aw_fire) & (w_held_q | w_fire) & ~bvalid_q;
  assign wr_addr = aw_held_q ? aw_addr_q : s_axil_awaddr_i[9:2];
  assign wr_data = w_held_q  ? w_data_q  : s_axil_wdata_i;
  assign wr_strb = w_held_q  ? w_strb_q  : s_axil_wstrb_i;

  // AW/W one-entry holding registers
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      aw_held_q <= 1'b0;
      aw_addr_q <= '0;
      w_held_q  <= 1'b0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
    end else begin
      if (wr_exec) begin
        aw_held_q <= 1'b0;
      end else if (aw_fire) begin
        aw_held_q <= 1'b1;
        aw_addr_q <= s_axil_awaddr_i[9:2];
      end
      if (wr_exec) begin
        w_held_q <= 1'b0;
      end else if (w_fire) begin
        w_held_q <= 1'b1;
        w_data_q <= s_axil_wdata_i;
        w_strb_q <= s_axil_wstrb_i;
      end
    end
  end

  // Write decode: select the target and the response for the executing write
  always_comb begin
    wr_dec      = decode_addr(wr_addr);
    csr_wr_mask = '0;
    ps2pl_push  = '0;
    wr_resp     = resp_slverr_c;
    if (wr_exec) begin
      case (wr_dec.region)
        region_csr_c: begin
          for (int i = 0; i < num_regs_p; i++) begin
            if (wr_dec.idx == 6'(i)) begin
              csr_wr_mask[i] = 1'b1;
              wr_resp        = resp_okay_c;
            end
          end
        end
        region_ps2pl_c: begin
          for (int j = 0; j < num_fifo_ps2pl_p; j++) begin
            if (wr_dec.idx == 6'(j) && ps2pl_ready[j]) begin
              ps2pl_push[j] = 1'b1;
              wr_resp       = resp_okay_c;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Write response channel
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      bvalid_q       <= 1'b0;
      s_axil_bresp_o <= resp_okay_c;
    end else if (wr_exec) begin
      bvalid_q       <= 1'b1;
      s_axil_bresp_o <= wr_resp;
    end else if (bvalid_q && s_axil_bready_i) begin
      bvalid_q <= 1'b0;
    end
  end

  // CSR bank with per-byte strobes and a one-cycle write pulse
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < num_regs_p; i++) csr_q[i] <= '0;
      csr_w_v_o <= '0;
    end else begin
      csr_w_v_o <= csr_wr_mask;
      for (int i = 0; i < num_regs_p; i++) begin
        for (int b = 0; b < 4; b++) begin
          if (csr_wr_mask[i] && wr_strb[b]) csr_q[i][8*b +: 8] <= wr_data[8*b +: 8];
        end
      end
    end
  end

  for (genvar i = 0; i < num_regs_p; i++) begin : g_csr_out
    assign csr_data_o[32*i +: 32] = csr_q[i];
  end

  // Read decode: data/response from pre-edge state; PL->PS pop on AR handshake
  always_comb begin
    rd_dec    = decode_addr(s_axil_araddr_i[9:2]);
    rd_data   = '0;
    rd_resp   = resp_slverr_c;
    pl2ps_pop = '0;
    case (rd_dec.region)
      region_csr_c: begin
        for (int i = 0; i < num_regs_p; i++) begin
          if (rd_dec.idx == 6'(i)) begin
            rd_data = csr_q[i];
            rd_resp = resp_okay_c;
          end
        end
      end
      region_ps2pl_c: begin
        for (int j = 0; j < num_fifo_ps2pl_p; j++) begin
          if (rd_dec.idx == 6'(j)) begin
            rd_data = 32'(fifo_els_p) - 32'(ps2pl_count[j]);
            rd_resp = resp_okay_c;
          end
        end
      end
      region_pl2ps_c: begin
        for (int k = 0; k < num_fifo_pl2ps_p; k++) begin
          if (rd_dec.idx == 6'(k) && pl2ps_v[k]) begin
            rd_data      = pl2ps_head[k];
            rd_resp      = resp_okay_c;
            pl2ps_pop[k] = ar_fire;
          end
        end
      end
      region_pl2ps_cnt_c: begin
        for (int k = 0; k < num_fifo_pl2ps_p; k++) begin
          if (rd_dec.idx == 6'(k)) begin
            rd_data = 32'(pl2ps_count[k]);
            rd_resp = resp_okay_c;
          end
        end
      end
      default: ;
    endcase
  end

  // Read data channel
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rvalid_q       <= 1'b0;
      s_axil_rdata_o <= '0;
      s_axil_rresp_o <= resp_okay_c;
    end else if (ar_fire) begin
      rvalid_q       <= 1'b1;
      s_axil_rdata_o <= rd_data;
      s_axil_rresp_o <= rd_resp;
    end else if (rvalid_q && s_axil_rready_i) begin
      rvalid_q <= 1'b0;
    end
  end

  for (genvar j = 0; j < num_fifo_ps2pl_p; j++) begin : g_ps2pl
    zynq_axil_shell_fifo #(.els_p(fifo_els_p)) u_fifo (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .data_i  (wr_data),
      .v_i     (ps2pl_push[j]),
      .ready_o (ps2pl_ready[j]),
      .data_o  (ps2pl_data_o[32*j +: 32]),
      .v_o     (ps2pl_v_o[j]),
      .yumi_i  (ps2pl_yumi_i[j]),
      .count_o (ps2pl_count[j])
    );
  end

  for (genvar k = 0; k < num_fifo_pl2ps_p; k++) begin : g_pl2ps
    zynq_axil_shell_fifo #(.els_p(fifo_els_p)) u_fifo (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .data_i  (pl2ps_data_i[32*k +: 32]),
      .v_i     (pl2ps_v_i[k]),
      .ready_o (pl2ps_ready_o[k]),
      .data_o  (pl2ps_head[k]),
      .v_o     (pl2ps_v[k]),
      .yumi_i  (pl2ps_pop[k]),
      .count_o (pl2ps_count[k])
    );
  end

endmodule

// File: tb/tb_zynq_axil_fifo_shell.sv
// Self-checking bench for zynq_axil_fifo_shell (default parameters).
// Model: CSR array plus queues per FIFO, updated when transactions complete.
module tb_zynq_axil_fifo_shell;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic [9:0]  awaddr, araddr;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic [127:0] csr_data_o;
  logic [3:0]  csr_w_v_o;
  logic [63:0] ps2pl_data_o, pl2ps_data_i;
  logic [1:0]  ps2pl_v_o, ps2pl_yumi_i, pl2ps_v_i, pl2ps_ready_o;

  int errors = 0;
  int checks = 0;
  bit cmp_en = 0;

  logic [31:0] m_csr [4];
  logic [31:0] m_ps2pl [2][$];
  logic [31:0] m_pl2ps [2][$];
  logic [3:0]  exp_pulse = '0;

  always #5 clk_i = ~clk_i;

  zynq_axil_fifo_shell dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .s_axil_awaddr_i(awaddr), .s_axil_awvalid_i(awvalid), .s_axil_awready_o(awready),
    .s_axil_wdata_i(wdata), .s_axil_wstrb_i(wstrb), .s_axil_wvalid_i(wvalid), .s_axil_wready_o(wready),
    .s_axil_bresp_o(bresp), .s_axil_bvalid_o(bvalid), .s_axil_bready_i(bready),
    .s_axil_araddr_i(araddr), .s_axil_arvalid_i(arvalid), .s_axil_arready_o(arready),
    .s_axil_rdata_o(rdata), .s_axil_rresp_o(rresp), .s_axil_rvalid_o(rvalid), .s_axil_rready_i(rready),
    .csr_data_o(csr_data_o), .csr_w_v_o(csr_w_v_o),
    .ps2pl_data_o(ps2pl_data_o), .ps2pl_v_o(ps2pl_v_o), .ps2pl_yumi_i(ps2pl_yumi_i),
    .pl2ps_data_i(pl2ps_data_i), .pl2ps_v_i(pl2ps_v_i), .pl2ps_ready_o(pl2ps_ready_o)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Advance to just after the next rising edge; CSR write pulses last one cycle
  task automatic tick();
    @(posedge clk_i);
    #1;
    exp_pulse = '0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_csr[i] = '0;
    for (int j = 0; j < 2; j++) begin
      m_ps2pl[j].delete();
      m_pl2ps[j].delete();
    end
    exp_pulse = '0;
  endtask

  task automatic model_write(input logic [9:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, output logic [1:0] resp);
    int idx;
    idx  = int'(addr[7:2]);
    resp = 2'b10;
    case (addr[9:8])
      2'b00: if (idx < 4) begin
        for (int b = 0; b < 4; b++) if (strb[b]) m_csr[idx][8*b +: 8] = data[8*b +: 8];
        exp_pulse[idx] = 1'b1;
        resp = 2'b00;
      end
      2'b01: if (idx < 2 && m_ps2pl[idx].size() < 16) begin
        m_ps2pl[idx].push_back(data);
        resp = 2'b00;
      end
      default: ;
    endcase
  endtask

  task automatic model_read(input logic [9:0] addr, output logic [31:0] data,
                            output logic [1:0] resp, output bit pop);
    int idx;
    idx  = int'(addr[7:2]);
    data = '0;
    resp = 2'b10;
    pop  = 0;
    if (idx < 4 && addr[9:8] == 2'b00) begin
      data = m_csr[idx]; resp = 2'b00;
    end else if (idx < 2) begin
      case (addr[9:8])
        2'b01: begin data = 32'(16 - m_ps2pl[idx].size()); resp = 2'b00; end
        2'b10: if (m_pl2ps[idx].size() > 0) begin
          data = m_pl2ps[idx][0]; resp = 2'b00; pop = 1;
        end
        2'b11: begin data = 32'(m_pl2ps[idx].size()); resp = 2'b00; end
        default: ;
      endcase
    end
  endtask

  // AW and W presented together, bready high throughout
  task automatic axi_write(input logic [9:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output logic [1:0] resp);
    logic [1:0] er;
    int n;
    awaddr = addr; awvalid = 1; wdata = data; wstrb = strb; wvalid = 1; bready = 1;
    check("wr_awready", awready, 1);
    check("wr_wready", wready, 1);
    tick();
    awvalid = 0; wvalid = 0;
    n = 0;
    while (!bvalid && n < 20) begin tick(); n++; end
    check("wr_latency", n, 0);
    model_write(addr, data, strb, er);
    resp = bresp;
    check("wr_bresp", bresp, er);
    tick();
    bready = 0;
    check("wr_b_done", bvalid, 0);
  endtask

  task automatic axi_read(input logic [9:0] addr, output logic [31:0] data, output logic [1:0] resp);
    logic [31:0] ed;
    logic [1:0]  er;
    bit pop;
    int n;
    araddr = addr; arvalid = 1; rready = 0;
    n = 0;
    while (!arready && n < 20) begin tick(); n++; end
    check("rd_ar_wait", n, 0);
    model_read(addr, ed, er, pop);
    tick();
    arvalid = 0;
    if (pop) void'(m_pl2ps[int'(addr[7:2])].pop_front());
    check("rd_rvalid", rvalid, 1);
    data = rdata; resp = rresp;
    check("rd_rdata", rdata, ed);
    check("rd_rresp", rresp, er);
    rready = 1;
    tick();
    rready = 0;
    check("rd_r_done", rvalid, 0);
  endtask

  task automatic pl_push(input int k, input logic [31:0] data);
    check("pl_push_ready", pl2ps_ready_o[k], 1);
    pl2ps_data_i[32*k +: 32] = data;
    pl2ps_v_i[k] = 1'b1;
    tick();
    pl2ps_v_i[k] = 1'b0;
    m_pl2ps[k].push_back(data);
  endtask

  task automatic pl_pop(input int j, output logic [31:0] data);
    check("pl_pop_v", ps2pl_v_o[j], 1);
    data = ps2pl_data_o[32*j +: 32];
    ps2pl_yumi_i[j] = 1'b1;
    tick();
    ps2pl_yumi_i[j] = 1'b0;
    if (m_ps2pl[j].size() > 0) void'(m_ps2pl[j].pop_front());
  endtask

  // Continuous comparison of the PL-facing outputs against the model
  always @(negedge clk_i) begin
    if (cmp_en && !reset_i) begin
      for (int i = 0; i < 4; i++) check($sformatf("csr_data[%0d]", i), csr_data_o[32*i +: 32], m_csr[i]);
      check("csr_w_v", {28'd0, csr_w_v_o}, {28'd0, exp_pulse});
      for (int j = 0; j < 2; j++) begin
        check($sformatf("ps2pl_v[%0d]", j), ps2pl_v_o[j], m_ps2pl[j].size() > 0);
        if (m_ps2pl[j].size() > 0) check($sformatf("ps2pl_data[%0d]", j), ps2pl_data_o[32*j +: 32], m_ps2pl[j][0]);
        check($sformatf("pl2ps_ready[%0d]", j), pl2ps_ready_o[j], m_pl2ps[j].size() < 16);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic [1:0]  r;
    logic [1:0]  er;
    reset_i = 1; awaddr = '0; awvalid = 0; wdata = '0; wstrb = '0; wvalid = 0; bready = 0;
    araddr = '0; arvalid = 0; rready = 0; ps2pl_yumi_i = '0; pl2ps_data_i = '0; pl2ps_v_i = '0;
    model_reset();
    repeat (3) @(posedge clk_i);
    #1;
    check("rst_bvalid", bvalid, 0);
    check("rst_rvalid", rvalid, 0);
    check("rst_awready", awready, 0);
    @(negedge clk_i);
    reset_i = 0;
    tick();
    cmp_en = 1;
    check("init_awready", awready, 1);
    check("init_ps2pl_v", ps2pl_v_o, 2'b00);
    check("init_pl2ps_ready", pl2ps_ready_o, 2'b11);
    check("init_csr", csr_data_o[31:0] | csr_data_o[63:32] | csr_data_o[95:64] | csr_data_o[127:96], 0);

    // Strobed CSR write
    axi_write(10'h004, 32'hDEADBEEF, 4'b0011, r);
    check("csr1_bresp", r, 2'b00);
    check("csr1_pulse_gone", csr_w_v_o, 4'b0000);
    axi_read(10'h004, d, r);
    check("csr1_rdata", d, 32'h0000BEEF);
    check("csr1_rresp", r, 2'b00);
    axi_write(10'h003, 32'h12345678, 4'hF, r);   // byte bits ignored -> CSR0
    axi_read(10'h000, d, r);
    check("csr0_rdata", d, 32'h12345678);
    axi_write(10'h200, 32'h1, 4'hF, r);
    check("pl2ps_wr_slverr", r, 2'b10);

    // Fill PS->PL FIFO 0, overflow, drain from PL
    for (int i = 0; i < 16; i++) begin
      axi_write(10'h100, 32'h1000 + 32'(i), 4'h0, r);
      check("fill_bresp", r, 2'b00);
    end
    axi_write(10'h100, 32'hBAD, 4'hF, r);
    check("overflow_bresp", r, 2'b10);
    axi_read(10'h100, d, r);
    check("full_free", d, 32'd0);
    axi_read(10'h104, d, r);
    check("fifo1_free", d, 32'd16);
    for (int i = 0; i < 16; i++) begin
      pl_pop(0, d);
      check("pop_order", d, 32'h1000 + 32'(i));
    end
    check("drained_v", ps2pl_v_o[0], 0);

    // PL->PS FIFO 1
    pl_push(1, 32'hCAFE0001);
    pl_push(1, 32'hCAFE0002);
    pl_push(1, 32'hCAFE0003);
    axi_read(10'h304, d, r);
    check("pl2ps_occ", d, 32'd3);
    for (int i = 1; i <= 3; i++) begin
      axi_read(10'h204, d, r);
      check("pl2ps_data", d, 32'hCAFE0000 + 32'(i));
      check("pl2ps_resp", r, 2'b00);
    end
    axi_read(10'h204, d, r);
    check("empty_pop_data", d, 32'd0);
    check("empty_pop_resp", r, 2'b10);

    // AW four cycles ahead of W, then stalled B
    awaddr = 10'h008; awvalid = 1; wvalid = 0; bready = 0;
    check("split_awready", awready, 1);
    tick();
    awvalid = 0;
    check("split_aw_held", awready, 0);
    for (int c = 0; c < 3; c++) begin
      tick();
      check("split_no_b", bvalid, 0);
    end
    wdata = 32'h55AA00FF; wstrb = 4'hF; wvalid = 1;
    check("split_wready", wready, 1);
    check("split_b_before", bvalid, 0);
    tick();
    wvalid = 0;
    check("split_b_lat", bvalid, 1);
    model_write(10'h008, 32'h55AA00FF, 4'hF, er);
    check("split_bresp", bresp, 2'b00);
    awaddr = 10'h00C; awvalid = 1;
    for (int c = 0; c < 4; c++) begin
      tick();
      awvalid = 0;
      check("stall_bvalid", bvalid, 1);
      check("stall_awready", awready, 0);
    end
    bready = 1;
    tick();
    bready = 0;
    check("stall_b_done", bvalid, 0);
    wdata = 32'hFFFFFF77; wstrb = 4'h1; wvalid = 1; bready = 1;
    tick();
    wvalid = 0;
    check("second_b", bvalid, 1);
    model_write(10'h00C, 32'hFFFFFF77, 4'h1, er);
    tick();
    bready = 0;
    axi_read(10'h00C, d, r);
    check("csr3_rdata", d, 32'h00000077);

    // Unmapped CSR index
    axi_write(10'h010, 32'hFFFFFFFF, 4'hF, r);
    check("unmapped_wr", r, 2'b10);
    axi_read(10'h010, d, r);
    check("unmapped_rd_resp", r, 2'b10);
    check("unmapped_rd_data", d, 32'd0);
    axi_read(10'h108, d, r);
    check("unmapped_fifo_resp", r, 2'b10);

    // Reset during an outstanding read with FIFO 0 partly full
    for (int i = 0; i < 5; i++) axi_write(10'h100, 32'h2000 + 32'(i), 4'hF, r);
    araddr = 10'h004; arvalid = 1; rready = 0;
    tick();
    arvalid = 0;
    check("pre_rst_rvalid", rvalid, 1);
    #2;
    reset_i = 1;
    cmp_en = 0;
    #1;
    check("rst_rvalid_now", rvalid, 0);
    check("rst_rdata", rdata, 0);
    check("rst_ps2pl_v", ps2pl_v_o, 2'b00);
    check("rst_csr1", csr_data_o[63:32], 0);
    model_reset();
    @(negedge clk_i);
    reset_i = 0;
    tick();
    cmp_en = 1;
    check("post_rst_ready", pl2ps_ready_o, 2'b11);
    axi_read(10'h100, d, r);
    check("post_rst_free", d, 32'd16);
    axi_read(10'h300, d, r);
    check("post_rst_occ", d, 32'd0);

    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
